event_count_ctrl: RTL and testbench

Parametrised start/count/terminate controller. A 3-state one-hot FSM gates a WIDTH-bit up-counter that advances on qualified events. It signals completion when a programmable limit is reached. It is the general successor of the fixed 4-bit count-to-all-ones controller, and sits between a start/event source and downstream logic that waits on `done`/`hit`.

---
 rtl/event_count_pkg.sv | 17 +
 rtl/ecc_counter.sv | 26 ++
 rtl/event_count_ctrl.sv | 111 +++++++++++
 tb/tb_event_count_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/event_count_pkg.sv
// Shared state encoding and mode constants for the event count controller.
package event_count_pkg;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_DONE = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001 << S_IDLE,
    ST_RUN  = 3'b001 << S_RUN,
    ST_DONE = 3'b001 << S_DONE
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/ecc_counter.sv
// WIDTH-bit up-counter with synchronous clear (dominant) and count enable.
module ecc_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/event_count_ctrl.sv
// Start/count/terminate controller: one-hot FSM gating an event counter that
// terminates (or reloads) when the limit latched at start is reached.
module event_count_ctrl
  import event_count_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit RELOAD_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             x,
  input  logic             reload,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             hit
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] lim_reg;
  logic             mode_reg;
  logic             hit_reg, hit_next;
  logic             latch_en;
  logic             cnt_clr, cnt_en;
  logic [WIDTH-1:0] cnt_value;
  logic             last_event;

  ecc_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cnt_value)
  );

  // Terminal event: the next qualified event lands the count on the limit.
  assign last_event = (cnt_value == lim_reg - WIDTH'(1));

  always_comb begin
    state_next = state_reg;
    hit_next   = 1'b0;
    latch_en   = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;

    if (abort) begin
      state_next = ST_IDLE;
    end else if (start) begin
      state_next = ST_RUN;
      latch_en   = 1'b1;
      cnt_clr    = 1'b1;
    end else begin
      unique case (state_reg)
        ST_RUN: begin
          if (lim_reg == '0) begin
            // Zero limit terminates on the first edge without waiting for x.
            hit_next = 1'b1;
            if (mode_reg == MODE_ONESHOT) begin
              state_next = ST_DONE;
            end
          end else if (x) begin
            if (last_event) begin
              hit_next = 1'b1;
              if (mode_reg == MODE_RELOAD) begin
                cnt_clr = 1'b1;
              end else begin
                cnt_en     = 1'b1;
                state_next = ST_DONE;
              end
            end else begin
              cnt_en = 1'b1;
            end
          end
        end
        ST_IDLE, ST_DONE: begin
          state_next = state_reg;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      lim_reg   <= '0;
      mode_reg  <= MODE_ONESHOT;
      hit_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      hit_reg   <= hit_next;
      if (latch_en) begin
        lim_reg  <= limit;
        mode_reg <= RELOAD_EN ? reload : MODE_ONESHOT;
      end
    end
  end

  assign count = cnt_value;
  assign busy  = state_reg[S_RUN];
  assign done  = state_reg[S_DONE];
  assign hit   = hit_reg;

endmodule

// File: tb/tb_event_count_ctrl.sv
// Randomised and directed bench for event_count_ctrl, with and without reload support.
module tb_event_count_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, x, reload;
  logic [3:0] limit;
  logic [3:0] count_a, count_b;
  logic       busy_a, busy_b, done_a, done_b, hit_a, hit_b;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model, index 0 = reload-capable instance, 1 = reload tied off
  int m_count[2];
  int m_lim[2];
  bit m_run[2];
  bit m_done[2];
  bit m_hit[2];
  bit m_rl[2];
  bit rl_allowed[2] = '{1'b1, 1'b0};

  always #5 clk = ~clk;

  event_count_ctrl #(.WIDTH(4), .RELOAD_EN(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .x(x),
    .reload(reload), .limit(limit), .count(count_a), .busy(busy_a),
    .done(done_a), .hit(hit_a)
  );

  event_count_ctrl #(.WIDTH(4), .RELOAD_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .x(x),
    .reload(reload), .limit(limit), .count(count_b), .busy(busy_b),
    .done(done_b), .hit(hit_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_count[d] = 0; m_lim[d] = 0; m_run[d] = 0;
      m_done[d] = 0; m_hit[d] = 0; m_rl[d] = 0;
    end
  endtask

  // One clock edge of behaviour, from the currently applied inputs.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      m_hit[d] = 0;
      if (abort) begin
        m_run[d] = 0; m_done[d] = 0;
      end else if (start) begin
        m_run[d] = 1; m_done[d] = 0; m_count[d] = 0;
        m_lim[d] = int'(limit);
        m_rl[d] = reload && rl_allowed[d];
      end else if (m_run[d]) begin
        if (m_lim[d] == 0) begin
          m_hit[d] = 1;
          if (!m_rl[d]) begin m_run[d] = 0; m_done[d] = 1; end
        end else if (x) begin
          m_count[d] = m_count[d] + 1;
          if (m_count[d] == m_lim[d]) begin
            m_hit[d] = 1;
            if (m_rl[d]) m_count[d] = 0;
            else begin m_run[d] = 0; m_done[d] = 1; end
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " a.count"}, int'(count_a), m_count[0]);
    check({tag, " a.busy"},  int'(busy_a),  int'(m_run[0]));
    check({tag, " a.done"},  int'(done_a),  int'(m_done[0]));
    check({tag, " a.hit"},   int'(hit_a),   int'(m_hit[0]));
    check({tag, " b.count"}, int'(count_b), m_count[1]);
    check({tag, " b.busy"},  int'(busy_b),  int'(m_run[1]));
    check({tag, " b.done"},  int'(done_b),  int'(m_done[1]));
    check({tag, " b.hit"},   int'(hit_b),   int'(m_hit[1]));
  endtask

  // Called at a falling edge; applies inputs, runs one edge, checks at the next fall.
  task automatic step(input string tag, input bit s, input bit a, input bit xx,
                      input bit rl, input int lim);
    start = s; abort = a; x = xx; reload = rl; limit = 4'(lim);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
    $display("step %-10s s=%0d a=%0d x=%0d rl=%0d lim=%0d -> a:cnt=%0d busy=%0d done=%0d hit=%0d  b:cnt=%0d busy=%0d done=%0d hit=%0d",
             tag, s, a, xx, rl, lim, count_a, busy_a, done_a, hit_a,
             count_b, busy_b, done_b, hit_b);
  endtask

  initial begin
    rst_n = 1'b0; start = 0; abort = 0; x = 0; reload = 0; limit = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_all("reset");

    // One-shot to 5, limit input changed mid-run
    step("os5_start", 1, 0, 0, 0, 5);
    for (int i = 0; i < 5; i++) step("os5_run", 0, 0, 1, 0, (i >= 2) ? 9 : 5);
    step("os5_hold", 0, 0, 1, 0, 9);
    step("os5_hold", 0, 0, 0, 0, 9);
    step("start_abort", 1, 1, 1, 0, 3);
    step("idle_x", 0, 0, 1, 0, 3);

    // All-ones limit with x toggling
    step("lim15", 1, 0, 0, 0, 15);
    for (int i = 0; i < 32; i++) step("lim15_run", 0, 0, (i % 2) == 0, 0, 15);

    // Auto-reload with limit 3
    step("rl3_start", 1, 0, 0, 1, 3);
    for (int i = 0; i < 10; i++) step("rl3_run", 0, 0, 1, 1, 3);
    step("abort", 0, 1, 0, 0, 3);

    // Zero limit, one-shot then reload
    step("lim0_os", 1, 0, 0, 0, 0);
    step("lim0_os", 0, 0, 0, 0, 0);
    step("lim0_os", 0, 0, 1, 0, 0);
    step("lim0_rl", 1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step("lim0_rl", 0, 0, i[0], 1, 0);

    // Restart mid-run with a new limit
    step("rs_start", 1, 0, 0, 0, 5);
    for (int i = 0; i < 3; i++) step("rs_run", 0, 0, 1, 0, 5);
    step("rs_restart", 1, 0, 1, 0, 7);
    for (int i = 0; i < 8; i++) step("rs_run2", 0, 0, 1, 0, 2);

    // Asynchronous reset at count 4
    step("ar_start", 1, 0, 0, 0, 9);
    for (int i = 0; i < 4; i++) step("ar_run", 0, 0, 1, 0, 9);
    start = 0; abort = 0; x = 1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("post_rst_x", 0, 0, 1, 0, 9);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step("rand",
           ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 39) == 0),
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1,
           ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
